// File: rtl/parking_entry_arbiter_if.sv
// Purpose: bundles the gate-side handshake and FIFO write-side signals of the
//          parking entry arbiter.
// Signals:
//   gate_req / gate_data        per-gate entry request and ticket
//   gate_ack / gate_reject      one-cycle per-gate outcome pulses
//   car_exit                    one-cycle pulse, one car left the lot
//   fifo_full / fifo_din        FIFO full flag and ticket presented to it
//   fifo_wen / fifo_enable      FIFO write enable and global enable
//   occupancy / lot_full / busy lot status and arbiter activity
// Modports: master = arbiter side, slave = gates/FIFO/environment side.
interface parking_entry_arbiter_if #(
    parameter int unsigned N_GATES = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CNT_W   = 7
);
    logic [N_GATES-1:0]        gate_req;
    logic [N_GATES*DATA_W-1:0] gate_data;
    logic [N_GATES-1:0]        gate_ack;
    logic [N_GATES-1:0]        gate_reject;
    logic                      car_exit;
    logic                      fifo_full;
    logic [DATA_W-1:0]         fifo_din;
    logic                      fifo_wen;
    logic                      fifo_enable;
    logic [CNT_W-1:0]          occupancy;
    logic                      lot_full;
    logic                      busy;

    modport master (
        input  gate_req, gate_data, car_exit, fifo_full,
        output gate_ack, gate_reject, fifo_din, fifo_wen, fifo_enable,
               occupancy, lot_full, busy
    );

    modport slave (
        output gate_req, gate_data, car_exit, fifo_full,
        input  gate_ack, gate_reject, fifo_din, fifo_wen, fifo_enable,
               occupancy, lot_full, busy
    );
endinterface

// File: rtl/parking_entry_arbiter.sv
// Purpose: round-robin arbiter sharing the car-ticket FIFO write port among
//          N_GATES entry gates, with lot occupancy tracking and full rejection.
// Ports:
//   clk_a  write-side clock
//   rst    synchronous, active-high reset
//   bus    parking_entry_arbiter_if.master (gate handshake, FIFO write side,
//          occupancy/lot_full/busy status)
module parking_entry_arbiter #(
    parameter int unsigned N_GATES      = 4,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned LOT_CAPACITY = 64,
    parameter int unsigned CNT_W        = 7
) (
    input  logic                     clk_a,
    input  logic                     rst,
    parking_entry_arbiter_if.master  bus
);

    localparam int unsigned PTR_W = (N_GATES > 1) ? $clog2(N_GATES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_ACK    = 2'd2,
        S_REJECT = 2'd3
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_win;
    logic [DATA_W-1:0]  r_fifo_din;
    logic [N_GATES-1:0] r_gate_ack;
    logic [N_GATES-1:0] r_gate_reject;
    logic               r_fifo_enable;
    logic [CNT_W-1:0]   r_occupancy;
    logic               r_lot_full;
    logic               r_busy;

    logic               w_any;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_ticket;
    logic               w_inc;
    logic               w_dec;
    logic [CNT_W-1:0]   w_occ_next;

    // First requesting gate at or after r_rr_ptr; scanning downward lets the
    // smallest offset overwrite the others.
    always_comb begin : arb_search
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = int'(N_GATES) - 1; i >= 0; i--) begin
            w_idx = PTR_W'((32'(r_rr_ptr) + 32'(i)) % N_GATES);
            if (bus.gate_req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Ticket of the current arbitration winner.
    always_comb begin : ticket_mux
        w_ticket = '0;
        for (int i = 0; i < int'(N_GATES); i++) begin
            if (w_win == PTR_W'(i)) begin
                w_ticket = bus.gate_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Admission and exit net out when they land in the same cycle; an exit at
    // an empty lot is ignored and the count saturates at capacity.
    always_comb begin : occ_next
        w_inc      = (r_state == S_ACK) && (r_occupancy < CNT_W'(LOT_CAPACITY));
        w_dec      = bus.car_exit && (r_occupancy != '0);
        w_occ_next = r_occupancy + CNT_W'(w_inc) - CNT_W'(w_dec);
    end

    // Transaction FSM with registered handshake outputs.
    always_ff @(posedge clk_a) begin : fsm
        if (rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_win         <= '0;
            r_fifo_din    <= '0;
            r_gate_ack    <= '0;
            r_gate_reject <= '0;
            r_fifo_enable <= 1'b0;
            r_occupancy   <= '0;
            r_lot_full    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_fifo_enable <= 1'b1;
            r_occupancy   <= w_occ_next;
            r_lot_full    <= (w_occ_next == CNT_W'(LOT_CAPACITY));
            r_gate_ack    <= '0;
            r_gate_reject <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win      <= w_win;
                        r_fifo_din <= w_ticket;
                        r_busy     <= 1'b1;
                        // Full check uses the count as of this cycle; an exit
                        // arriving now only counts from the next arbitration.
                        if (r_lot_full) begin
                            r_state       <= S_REJECT;
                            r_gate_reject <= N_GATES'(1) << w_win;
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (!bus.fifo_full) begin
                        r_state    <= S_ACK;
                        r_gate_ack <= N_GATES'(1) << r_win;
                    end
                end
                S_ACK, S_REJECT: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= PTR_W'((32'(r_win) + 32'd1) % N_GATES);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe follows the FIFO full flag directly so a stalled write
    // fires in the very cycle space appears.
    assign bus.fifo_wen    = (r_state == S_WRITE) && !bus.fifo_full;
    assign bus.fifo_din    = r_fifo_din;
    assign bus.gate_ack    = r_gate_ack;
    assign bus.gate_reject = r_gate_reject;
    assign bus.fifo_enable = r_fifo_enable;
    assign bus.occupancy   = r_occupancy;
    assign bus.lot_full    = r_lot_full;
    assign bus.busy        = r_busy;

endmodule
